// File: rtl/fifo_flex.sv
// fifo_flex: parametrised valid/ready elastic buffer of arbitrary depth.
//
// Storage is a Depth-entry array addressed by Depth-modulo read/write pointers
// (no power-of-two requirement). A separate occupancy counter drives the
// full/empty and programmable almost-full/almost-empty flags, so every status
// flag is a pure decode of registered state.
//
// Optional feature macro: FIFO_FALL_THROUGH_EN
//   defined   : an empty FIFO forwards data_in_i straight to data_out_o
//               (zero-cycle latency); a same-cycle push/pop while empty
//               bypasses the storage entirely.
//   undefined : data_out_valid_o is low whenever the FIFO is empty, so the
//               minimum latency is one cycle.
//
// Ports:
//   clk_i            in   1          clock, rising edge
//   srst_i           in   1          synchronous active-high reset
//   flush_i          in   1          synchronous flush, discards contents
//   data_in_i        in   DataWidth  write payload
//   data_in_valid_i  in   1          write valid
//   data_in_ready_o  out  1          write ready
//   data_out_o       out  DataWidth  read payload
//   data_out_valid_o out  1          read valid
//   data_out_ready_i in   1          read ready
//   count_o          out  CW         entries held, CW = $clog2(Depth+1)
//   full_o           out  1          count_o == Depth
//   empty_o          out  1          count_o == 0
//   almost_full_o    out  1          count_o >= AlmostFullThr
//   almost_empty_o   out  1          count_o <= AlmostEmptyThr
module fifo_flex #(
    parameter int unsigned DataWidth      = 8,
    parameter int unsigned Depth          = 5,
    parameter int unsigned AlmostFullThr  = Depth - 1,
    parameter int unsigned AlmostEmptyThr = 1,
    localparam int unsigned CW            = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] data_in_i,
    input  logic                 data_in_valid_i,
    output logic                 data_in_ready_o,
    output logic [DataWidth-1:0] data_out_o,
    output logic                 data_out_valid_o,
    input  logic                 data_out_ready_i,
    output logic [CW-1:0]        count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o
);

    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataWidth-1:0] r_mem [Depth];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_block;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [PW-1:0]        w_rd_ptr_nxt;
    logic [PW-1:0]        w_wr_ptr_nxt;
    logic [CW-1:0]        w_count_nxt;

    // Occupancy decode, shared by handshake logic and status outputs.
    assign w_full  = (r_count == CW'(Depth));
    assign w_empty = (r_count == '0);

    // Reset and flush cycles carry no handshakes in either direction.
    assign w_block = srst_i | flush_i;

    // Write side: a full FIFO still accepts when the reader drains this cycle.
    assign data_in_ready_o = !w_block & (!w_full | data_out_ready_i);

    // Read side, with optional empty-FIFO forwarding.
    always_comb begin
        data_out_valid_o = !w_block & !w_empty;
        data_out_o       = r_mem[r_rd_ptr];
        w_bypass         = 1'b0;
`ifdef FIFO_FALL_THROUGH_EN
        if (w_empty) begin
            data_out_valid_o = !w_block & data_in_valid_i;
            data_out_o       = data_in_i;
            w_bypass         = data_in_valid_i & data_out_ready_i & !w_block;
        end
`endif
    end

    assign w_push = data_in_valid_i & data_in_ready_o;
    assign w_pop  = data_out_valid_o & data_out_ready_i;

    // A forwarded beat never touches storage, pointers or count.
    assign w_wr_en = w_push & !w_bypass;
    assign w_rd_en = w_pop & !w_bypass;

    // Depth-modulo pointer advance: Depth-1 wraps to 0.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_wr_en) begin
            w_wr_ptr_nxt = (r_wr_ptr == PW'(Depth - 1)) ? '0 : r_wr_ptr + PW'(1);
        end
        if (w_rd_en) begin
            w_rd_ptr_nxt = (r_rd_ptr == PW'(Depth - 1)) ? '0 : r_rd_ptr + PW'(1);
        end
    end

    // Count changes only when exactly one side moves.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_en && !w_rd_en) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_en && w_rd_en) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Control state; reset takes priority over flush.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= data_in_i;
        end
    end

    // Status flags decode the count register only.
    assign count_o        = r_count;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (r_count >= CW'(AlmostFullThr));
    assign almost_empty_o = (r_count <= CW'(AlmostEmptyThr));

    // Occupancy and pointer range invariants.
    a_count_bound : assert property (@(posedge clk_i) disable iff (srst_i)
        r_count <= CW'(Depth));
    a_wr_ptr_bound : assert property (@(posedge clk_i) disable iff (srst_i)
        r_wr_ptr <= PW'(Depth - 1));
    a_rd_ptr_bound : assert property (@(posedge clk_i) disable iff (srst_i)
        r_rd_ptr <= PW'(Depth - 1));

endmodule
